// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - LC-3 opcodes, address-mux encodings and memory-sequencer state type
package lc3_pkg;

  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_LEA = 4'b1110;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_STR = 4'b0111;

  localparam logic       SEL_ADDR1_PC    = 1'b0;
  localparam logic       SEL_ADDR1_BASE  = 1'b1;
  localparam logic [1:0] SEL_ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] SEL_ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] SEL_ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] SEL_ADDR2_OFF11 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EA,
    ST_READ,
    ST_IND,
    ST_WRITE,
    ST_WB,
    ST_FIN
  } mem_seq_state_t;

  // LDR/STR address off a base register with a 6-bit offset; the rest are PC-relative.
  function automatic logic is_base_mode(input logic [3:0] op);
    return (op == OP_LDR) || (op == OP_STR);
  endfunction

endpackage

// File: rtl/lc3_wait_timer.sv
// rtl/lc3_wait_timer.sv - memory wait counter with terminal-count flag
// tc is high during the TIMEOUT_CYC-th consecutive wait cycle; TIMEOUT_CYC = 0 never fires.
module lc3_wait_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && !tc) begin
      r_count <= r_count + W'(1);
    end
  end

  assign tc = (TIMEOUT_CYC != 0) && (r_count == W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/lc3_mem_seq.sv
// rtl/lc3_mem_seq.sv - multi-cycle sequencer for LC-3 LD/LDI/LDR/LEA/ST/STI/STR
module lc3_mem_seq
  import lc3_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] ir,
  input  logic [15:0] sr_data,
  input  logic [15:0] eab_in,
  input  logic [15:0] mem_rdata,
  input  logic        mem_r,
  output logic        sel_addr1,
  output logic [1:0]  sel_addr2,
  output logic [2:0]  sr1_sel,
  output logic [2:0]  sr_sel,
  output logic [15:0] mar,
  output logic [15:0] mdr,
  output logic        mem_en,
  output logic        mem_we,
  output logic        ld_reg,
  output logic        ld_cc,
  output logic [2:0]  dr,
  output logic [15:0] wb_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  mem_seq_state_t r_state, w_next;

  logic [15:0] r_ir;
  logic [15:0] r_mar;
  logic [15:0] r_mdr;
  logic        r_ind;
  logic        r_err;

  logic [3:0]  w_op;
  logic        w_accept;
  logic        w_ld_mar_eab;
  logic        w_ld_mar_mdr;
  logic        w_ld_mdr_sr;
  logic        w_ld_mdr_mem;
  logic        w_set_ind;
  logic        w_set_err;
  logic        w_tmr_clr;
  logic        w_tmr_inc;
  logic        w_tmr_tc;
  logic        w_unused_ir;

  assign w_op        = r_ir[15:12];
  assign w_unused_ir = ^r_ir[5:0];

  assign sr1_sel = r_ir[8:6];
  assign sr_sel  = r_ir[11:9];
  assign dr      = r_ir[11:9];
  assign mar     = r_mar;
  assign mdr     = r_mdr;
  assign busy    = (r_state != ST_IDLE);

  // Counter restarts every time an access begins, including the second read of LDI.
  assign w_tmr_clr = !((r_state == ST_READ) || (r_state == ST_WRITE));
  assign w_tmr_inc = mem_en && !mem_r;

  lc3_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wait_timer (
    .clk (clk),
    .rst (rst),
    .clr (w_tmr_clr),
    .inc (w_tmr_inc),
    .tc  (w_tmr_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_ld_mar_eab = 1'b0;
    w_ld_mar_mdr = 1'b0;
    w_ld_mdr_sr  = 1'b0;
    w_ld_mdr_mem = 1'b0;
    w_set_ind    = 1'b0;
    w_set_err    = 1'b0;
    sel_addr1    = SEL_ADDR1_PC;
    sel_addr2    = SEL_ADDR2_ZERO;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    ld_reg       = 1'b0;
    ld_cc        = 1'b0;
    wb_data      = 16'h0000;
    done         = 1'b0;
    err          = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = ST_EA;
        end
      end

      ST_EA: begin
        if (is_base_mode(w_op)) begin
          sel_addr1 = SEL_ADDR1_BASE;
          sel_addr2 = SEL_ADDR2_OFF6;
        end else begin
          sel_addr1 = SEL_ADDR1_PC;
          sel_addr2 = SEL_ADDR2_OFF9;
        end
        w_ld_mar_eab = 1'b1;
        w_set_ind    = (w_op == OP_LDI) || (w_op == OP_STI);
        case (w_op)
          OP_LEA:                        w_next = ST_WB;
          OP_LD, OP_LDR, OP_LDI, OP_STI: w_next = ST_READ;
          OP_ST, OP_STR: begin
            w_ld_mdr_sr = 1'b1;
            w_next      = ST_WRITE;
          end
          default: begin
            w_set_err = 1'b1;
            w_next    = ST_FIN;
          end
        endcase
      end

      ST_READ: begin
        mem_en = 1'b1;
        if (mem_r) begin
          w_ld_mdr_mem = 1'b1;
          w_next       = r_ind ? ST_IND : ST_WB;
        end else if (w_tmr_tc) begin
          w_set_err = 1'b1;
          w_next    = ST_FIN;
        end
      end

      // MDR holds the pointer; it becomes the address of the second access.
      ST_IND: begin
        w_ld_mar_mdr = 1'b1;
        if (w_op == OP_STI) begin
          w_ld_mdr_sr = 1'b1;
          w_next      = ST_WRITE;
        end else begin
          w_next = ST_READ;
        end
      end

      ST_WRITE: begin
        mem_en = 1'b1;
        mem_we = 1'b1;
        if (mem_r) begin
          w_next = ST_FIN;
        end else if (w_tmr_tc) begin
          w_set_err = 1'b1;
          w_next    = ST_FIN;
        end
      end

      ST_WB: begin
        ld_reg  = 1'b1;
        ld_cc   = (w_op != OP_LEA);
        wb_data = (w_op == OP_LEA) ? r_mar : r_mdr;
        w_next  = ST_FIN;
      end

      ST_FIN: begin
        done   = 1'b1;
        err    = r_err;
        w_next = ST_IDLE;
      end

      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ir  <= 16'h0000;
      r_mar <= 16'h0000;
      r_mdr <= 16'h0000;
      r_ind <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ir <= ir;
      end

      if (w_ld_mar_eab) begin
        r_mar <= eab_in;
      end else if (w_ld_mar_mdr) begin
        r_mar <= r_mdr;
      end

      if (w_ld_mdr_sr) begin
        r_mdr <= sr_data;
      end else if (w_ld_mdr_mem) begin
        r_mdr <= mem_rdata;
      end

      if (w_accept || w_ld_mar_mdr) begin
        r_ind <= 1'b0;
      end else if (w_set_ind) begin
        r_ind <= 1'b1;
      end

      if (w_accept) begin
        r_err <= 1'b0;
      end else if (w_set_err) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lc3_mem_seq.sv
// tb/tb_lc3_mem_seq.sv - self-checking bench for lc3_mem_seq
module tb_lc3_mem_seq;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] ir;
  logic [15:0] sr_data;
  logic [15:0] eab_in;
  logic [15:0] mem_rdata;
  logic        mem_r;
  logic        sel_addr1;
  logic [1:0]  sel_addr2;
  logic [2:0]  sr1_sel;
  logic [2:0]  sr_sel;
  logic [15:0] mar;
  logic [15:0] mdr;
  logic        mem_en;
  logic        mem_we;
  logic        ld_reg;
  logic        ld_cc;
  logic [2:0]  dr;
  logic [15:0] wb_data;
  logic        busy;
  logic        done;
  logic        err;

  lc3_mem_seq #(.TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ir        (ir),
    .sr_data   (sr_data),
    .eab_in    (eab_in),
    .mem_rdata (mem_rdata),
    .mem_r     (mem_r),
    .sel_addr1 (sel_addr1),
    .sel_addr2 (sel_addr2),
    .sr1_sel   (sr1_sel),
    .sr_sel    (sr_sel),
    .mar       (mar),
    .mdr       (mdr),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .ld_reg    (ld_reg),
    .ld_cc     (ld_cc),
    .dr        (dr),
    .wb_data   (wb_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        err;
    int          nwb;
    logic [15:0] wb;
    logic        cc;
    logic [2:0]  dr;
    int          nacc;
    logic [15:0] first;
    logic [15:0] last;
    logic        we;
    logic [15:0] data;
    logic        sel1;
    logic [1:0]  sel2;
    logic        proto;
    logic        idle_ok;
  } res_t;

  typedef struct {
    string       name;
    logic [15:0] ir;
    logic [15:0] sr;
    logic [15:0] eab;
    int          w0;
    int          w1;
    bit          poke;
    res_t        exp;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] mem_init [logic [15:0]];

  function automatic logic [15:0] mem_read(input logic [15:0] a);
    if (mem_init.exists(a)) return mem_init[a];
    return {a[7:0], a[15:8]} ^ 16'hA5C3;
  endfunction

  task automatic check(input string tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s.%s: got %0h expected %0h", tag, nm, act, exp);
    else n_pass++;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, "mar", 32'(mar), 32'h0);
    check(tag, "mdr", 32'(mdr), 32'h0);
    check(tag, "mem_en", 32'(mem_en), 32'h0);
    check(tag, "wb_data", 32'(wb_data), 32'h0);
    check(tag, "busy", 32'(busy), 32'h0);
    check(tag, "ctrl", 32'({sel_addr1, sel_addr2, sr1_sel, sr_sel, mem_we, ld_reg, ld_cc, dr, done, err}), 32'h0);
  endtask

  function automatic vec_t mk(input string name, input logic [15:0] i_ir, input logic [15:0] sr,
                              input logic [15:0] eab, input int w0, input int w1, input bit poke,
                              input int cyc, input logic e_err, input int nwb, input logic [15:0] wb,
                              input logic cc, input logic [2:0] e_dr, input int nacc,
                              input logic [15:0] first, input logic [15:0] last, input logic we,
                              input logic [15:0] data, input logic sel1, input logic [1:0] sel2);
    vec_t v;
    v.name = name; v.ir = i_ir; v.sr = sr; v.eab = eab; v.w0 = w0; v.w1 = w1; v.poke = poke;
    v.exp = '{cyc:cyc, err:e_err, nwb:nwb, wb:wb, cc:cc, dr:e_dr, nacc:nacc, first:first, last:last,
              we:we, data:data, sel1:sel1, sel2:sel2, proto:1'b1, idle_ok:1'b1};
    return v;
  endfunction

  // Reference: counts cycles from the instruction's phases and walks the access chain.
  task automatic model(input vec_t v, output res_t e);
    logic [3:0]  op;
    logic [15:0] addr;
    int          n, w;
    bit          is_load, is_write_op, indirect, timed_out, wr;
    e = '{cyc:0, err:0, nwb:0, wb:0, cc:0, dr:0, nacc:0, first:0, last:0, we:0, data:0,
          sel1:0, sel2:0, proto:1, idle_ok:1};
    op          = v.ir[15:12];
    e.sel1      = (op == 4'h6) || (op == 4'h7);
    e.sel2      = e.sel1 ? 2'd1 : 2'd2;
    is_load     = op inside {4'h2, 4'hA, 4'h6};
    is_write_op = op inside {4'h3, 4'h7, 4'hB};
    indirect    = op inside {4'hA, 4'hB};
    e.cyc       = 1;
    if (op == 4'hE) begin
      e.cyc += 2; e.nwb = 1; e.wb = v.eab; e.cc = 0; e.dr = v.ir[11:9];
    end else if (!(is_load || is_write_op)) begin
      e.cyc += 1; e.err = 1;
    end else begin
      n = indirect ? 2 : 1;
      addr = v.eab;
      timed_out = 0;
      wr = 0;
      for (int k = 0; k < n && !timed_out; k++) begin
        w  = (k == 0) ? v.w0 : v.w1;
        wr = (k == n - 1) && is_write_op;
        e.nacc++;
        if (k == 0) e.first = addr;
        e.last = addr; e.we = wr; e.data = wr ? v.sr : 16'h0;
        if (w >= TO) begin
          e.cyc += TO; timed_out = 1; e.err = 1;
        end else begin
          e.cyc += w + 1;
          if (k < n - 1) begin e.cyc += 1; addr = mem_read(addr); end
        end
      end
      if (!timed_out && !wr) begin
        e.cyc += 1; e.nwb = 1; e.wb = mem_read(addr); e.cc = 1; e.dr = v.ir[11:9];
      end
      e.cyc += 1;
    end
  endtask

  // Starts at a falling edge (cycle 0) and plays the memory side until one cycle past done.
  task automatic run(input vec_t v, output res_t o);
    bit got_done, in_acc;
    int acc_idx, acc_cyc, w;
    o = '{cyc:0, err:0, nwb:0, wb:0, cc:0, dr:0, nacc:0, first:0, last:0, we:0, data:0,
          sel1:0, sel2:0, proto:1, idle_ok:0};
    ir = v.ir; sr_data = v.sr; eab_in = v.eab; start = 1'b1;
    got_done = 0; in_acc = 0; acc_idx = -1; acc_cyc = 0;
    for (int c = 1; c <= 60 && !got_done; c++) begin
      @(negedge clk);
      start = v.poke && (c == 2 || c == 3);
      if (start) ir = 16'hE000;
      if (c == 1) begin
        o.sel1 = sel_addr1; o.sel2 = sel_addr2;
      end else if (sel_addr1 || sel_addr2 != 2'b00) o.proto = 0;
      if (ld_reg) begin
        o.nwb++; o.wb = wb_data; o.cc = ld_cc; o.dr = dr;
      end else if (ld_cc) o.proto = 0;
      if (mem_en) begin
        if (!in_acc) begin
          in_acc = 1; acc_cyc = 0; acc_idx++; o.nacc++;
          if (o.nacc == 1) o.first = mar;
          o.last = mar; o.we = mem_we; o.data = mem_we ? mdr : 16'h0;
        end else if (mar != o.last || mem_we != o.we || (mem_we && mdr != o.data)) o.proto = 0;
        w = (acc_idx == 0) ? v.w0 : v.w1;
        mem_r = (acc_cyc == w);
        mem_rdata = mem_r ? mem_read(mar) : 16'hDEAD;
        acc_cyc++;
      end else begin
        in_acc = 0;
        mem_r = 1'($urandom_range(0, 1));
        mem_rdata = 16'($urandom);
      end
      if (done) begin got_done = 1; o.cyc = c; o.err = err; end
    end
    @(negedge clk);
    start = 1'b0; mem_r = 1'b0;
    o.idle_ok = !busy && !mem_en && !done;
  endtask

  task automatic compare(input string tag, input res_t o, input res_t e);
    check(tag, "done_cycle", 32'(o.cyc), 32'(e.cyc));
    check(tag, "err", 32'(o.err), 32'(e.err));
    check(tag, "ld_reg_count", 32'(o.nwb), 32'(e.nwb));
    check(tag, "wb_data", 32'(o.wb), 32'(e.wb));
    check(tag, "ld_cc", 32'(o.cc), 32'(e.cc));
    check(tag, "dr", 32'(o.dr), 32'(e.dr));
    check(tag, "access_count", 32'(o.nacc), 32'(e.nacc));
    check(tag, "first_mar", 32'(o.first), 32'(e.first));
    check(tag, "last_mar", 32'(o.last), 32'(e.last));
    check(tag, "mem_we", 32'(o.we), 32'(e.we));
    check(tag, "write_mdr", 32'(o.data), 32'(e.data));
    check(tag, "sel_addr1", 32'(o.sel1), 32'(e.sel1));
    check(tag, "sel_addr2", 32'(o.sel2), 32'(e.sel2));
    check(tag, "protocol", 32'(o.proto), 32'(e.proto));
    check(tag, "idle_after_done", 32'(o.idle_ok), 32'(e.idle_ok));
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    res_t o, e;
    logic [3:0] ops [10];
    logic [31:0] r;

    rst = 1'b1; start = 1'b0; ir = '0; sr_data = '0; eab_in = '0; mem_rdata = '0; mem_r = 1'b0;

    mem_init[16'h4000] = 16'h8001;
    mem_init[16'h3100] = 16'hC000;
    mem_init[16'hC000] = 16'h1234;
    mem_init[16'h3200] = 16'h5000;

    //          name       ir        sr        eab       w0 w1 pk  cyc err nwb wb       cc dr nacc first     last      we data      s1 s2
    tbl.push_back(mk("lea",    16'hE5FF, 16'h0000, 16'h3000, 0, 0, 0, 3, 0, 1, 16'h3000, 0, 2, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 2));
    tbl.push_back(mk("ldr",    16'h627F, 16'h0000, 16'h4000, 2, 0, 0, 6, 0, 1, 16'h8001, 1, 1, 1, 16'h4000, 16'h4000, 0, 16'h0000, 1, 1));
    tbl.push_back(mk("ldi",    16'hA005, 16'h0000, 16'h3100, 0, 0, 0, 6, 0, 1, 16'h1234, 1, 0, 2, 16'h3100, 16'hC000, 0, 16'h0000, 0, 2));
    tbl.push_back(mk("sti",    16'hB810, 16'hBEEF, 16'h3200, 0, 0, 0, 5, 0, 0, 16'h0000, 0, 0, 2, 16'h3200, 16'h5000, 1, 16'hBEEF, 0, 2));
    tbl.push_back(mk("st_to",  16'h3A07, 16'h1111, 16'h2000, 9, 0, 0, 6, 1, 0, 16'h0000, 0, 0, 1, 16'h2000, 16'h2000, 1, 16'h1111, 0, 2));
    tbl.push_back(mk("rti",    16'h8000, 16'h0000, 16'h0000, 0, 0, 0, 2, 1, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 2));
    tbl.push_back(mk("ld_wrap",16'h2FFF, 16'h0000, 16'hFFFF, 1, 0, 0, 5, 0, 1, 16'h5A3C, 1, 7, 1, 16'hFFFF, 16'hFFFF, 0, 16'h0000, 0, 2));
    tbl.push_back(mk("str",    16'h7C81, 16'hCAFE, 16'h0000, 0, 0, 0, 3, 0, 0, 16'h0000, 0, 0, 1, 16'h0000, 16'h0000, 1, 16'hCAFE, 1, 1));
    tbl.push_back(mk("str_w3", 16'h7C81, 16'h0F0F, 16'h1234, 3, 0, 0, 6, 0, 0, 16'h0000, 0, 0, 1, 16'h1234, 16'h1234, 1, 16'h0F0F, 1, 1));
    tbl.push_back(mk("ldi_to", 16'hA005, 16'h0000, 16'h3100, 0, 4, 0, 8, 1, 0, 16'h0000, 0, 0, 2, 16'h3100, 16'hC000, 0, 16'h0000, 0, 2));
    tbl.push_back(mk("ld_poke",16'h2620, 16'h0000, 16'h0042, 2, 0, 1, 6, 0, 1, 16'hE7C3, 1, 3, 1, 16'h0042, 16'h0042, 0, 16'h0000, 0, 2));

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    foreach (tbl[i]) begin
      run(tbl[i], o);
      compare(tbl[i].name, o, tbl[i].exp);
    end

    // Asynchronous reset in the middle of a read must clear outputs before any clock edge.
    ir = 16'h2400; eab_in = 16'h1111; start = 1'b1; mem_r = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk); mem_r = 1'b0;
    check("rst_mid", "mem_en_in_read", 32'(mem_en), 32'h1);
    check("rst_mid", "mar_in_read", 32'(mar), 32'h1111);
    #2 rst = 1'b1;
    #1 check_all_zero("rst_mid");
    @(negedge clk); rst = 1'b0;

    ops = '{4'h2, 4'hA, 4'h6, 4'hE, 4'h3, 4'hB, 4'h7, 4'h8, 4'h0, 4'hD};
    for (int i = 0; i < 60; i++) begin
      r = $urandom;
      v.name = $sformatf("rand%0d", i);
      v.ir   = {ops[$urandom_range(0, 9)], r[11:0]};
      v.sr   = 16'($urandom);
      v.eab  = 16'($urandom);
      v.w0   = $urandom_range(0, 5);
      v.w1   = $urandom_range(0, 5);
      v.poke = ($urandom_range(0, 3) == 0);
      model(v, e);
      run(v, o);
      compare(v.name, o, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
